// File: rtl/zbt_port_ctrl_pkg.sv
// Shared constants and FSM encoding for the ZBT port controller.
// Holds the default bus widths, the settle time and the pipeline depth.
package zbt_port_ctrl_pkg;

    localparam int DEF_ADDR_W     = 19;
    localparam int DEF_DATA_W     = 36;
    localparam int DEF_SETTLE_CYC = 16;

    // Stages from request acceptance to the pad data register
    localparam int PIPE_DEPTH = 3;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/zbt_port_ctrl_if.sv
// User request/response bus plus the ZBT pad-side signals of the port controller.
// The controller uses the slave modport; the user and pad side use the master modport.
interface zbt_port_ctrl_if
    import zbt_port_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we_b;
    logic              ram_cen_b;
    logic [DATA_W-1:0] ram_dout;
    logic              ram_doe;
    logic [DATA_W-1:0] ram_din;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, ram_din,
        input  req_ready, rsp_valid, rsp_rdata,
        input  ram_addr, ram_we_b, ram_cen_b, ram_dout, ram_doe
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, ram_din,
        output req_ready, rsp_valid, rsp_rdata,
        output ram_addr, ram_we_b, ram_cen_b, ram_dout, ram_doe
    );

endinterface

// File: rtl/zbt_pipe_stage.sv
// One operation-tracking stage: valid/we tag plus write data.
// Clear kills the tag so a discarded operation never reaches the pads or the response.
module zbt_pipe_stage
    import zbt_port_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic              in_we,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_we,
    output logic [DATA_W-1:0] out_data
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_we    <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid && !clear;
            out_we    <= in_we;
            out_data  <= in_data;
        end
    end

endmodule

// File: rtl/zbt_port_ctrl.sv
// Pipelined ZBT SRAM port controller: waits for clock lock, settles, then issues
// one read or write per cycle with write data two cycles and read data three cycles behind.
module zbt_port_ctrl
    import zbt_port_ctrl_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           locked,
    output logic           ready_state,
    zbt_port_ctrl_if.slave bus
);

    localparam int               CNT_W    = cnt_width(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             run_go;
    logic             accept;

    logic [PIPE_DEPTH:0]             st_valid;
    logic [PIPE_DEPTH:0]             st_we;
    logic [PIPE_DEPTH:0][DATA_W-1:0] st_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= WAIT_LOCK;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            WAIT_LOCK: begin
                cnt_next = '0;
                if (locked) state_next = SETTLE;
            end
            SETTLE: begin
                if (!locked)                state_next = WAIT_LOCK;
                else if (cnt_reg == CNT_LAST) state_next = RUN;
                else                        cnt_next   = cnt_reg + CNT_W'(1);
            end
            RUN: begin
                if (!locked) state_next = WAIT_LOCK;
            end
            default: state_next = WAIT_LOCK;
        endcase
    end

    // Losing lock in RUN drops ready in the same cycle so nothing new is accepted
    always_comb begin
        ready_state   = (state_reg == RUN);
        run_go        = ready_state && locked;
        bus.req_ready = run_go;
    end

    assign accept      = bus.req_valid && run_go;
    assign st_valid[0] = accept;
    assign st_we[0]    = bus.req_we;
    assign st_data[0]  = bus.req_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
            zbt_pipe_stage #(.DATA_W(DATA_W)) u_stage (
                .clock     (clock),
                .reset_n   (reset_n),
                .clear     (!run_go),
                .in_valid  (st_valid[gi]),
                .in_we     (st_we[gi]),
                .in_data   (st_data[gi]),
                .out_valid (st_valid[gi+1]),
                .out_we    (st_we[gi+1]),
                .out_data  (st_data[gi+1])
            );
        end
    endgenerate

    // Last stage drives the pad data for the cycle the RAM expects write data
    assign bus.ram_doe  = st_valid[PIPE_DEPTH] && st_we[PIPE_DEPTH];
    assign bus.ram_dout = st_data[PIPE_DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.ram_addr  <= '0;
            bus.ram_we_b  <= 1'b1;
            bus.ram_cen_b <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            if (accept) bus.ram_addr <= bus.req_addr;
            bus.ram_we_b  <= !(accept && bus.req_we);
            bus.ram_cen_b <= !run_go;
            bus.rsp_valid <= run_go && st_valid[PIPE_DEPTH] && !st_we[PIPE_DEPTH];
            if (run_go && st_valid[PIPE_DEPTH] && !st_we[PIPE_DEPTH])
                bus.rsp_rdata <= bus.ram_din;
        end
    end

endmodule

// File: tb/tb_zbt_port_ctrl.sv
// Directed and table-driven checks of zbt_port_ctrl against a behavioural pipelined ZBT
// model and an accept-order scoreboard.
module tb_zbt_port_ctrl;

    logic clock;
    logic reset_n;
    logic locked;
    logic ready_state;
    logic [35:0] din_q;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    zbt_port_ctrl_if #(.ADDR_W(19), .DATA_W(36)) bus ();

    zbt_port_ctrl #(.ADDR_W(19), .DATA_W(36), .SETTLE_CYC(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .locked      (locked),
        .ready_state (ready_state),
        .bus         (bus)
    );

    assign bus.ram_din = din_q;

    initial clock = 1'b0;
    always #10 clock = ~clock;

    always @(posedge clock or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] init_val(input int a);
        return 36'hA5A5_00000 ^ 36'(a);
    endfunction

    // Behavioural pipelined ZBT: address sampled at E1, write data taken at E3,
    // read data presented between E2 and E3.
    logic [35:0] mem [int];
    logic        m1_v, m1_we, m2_v, m2_we;
    int          m1_addr, m2_addr;

    function automatic logic [35:0] mem_rd(input int a);
        if (mem.exists(a)) return mem[a];
        return init_val(a);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m1_v = 1'b0; m2_v = 1'b0; m1_we = 1'b0; m2_we = 1'b0;
            m1_addr = 0; m2_addr = 0;
            din_q <= '0;
        end else begin
            if (m2_v && m2_we && bus.ram_doe) mem[m2_addr] = bus.ram_dout;
            m2_v = m1_v; m2_we = m1_we; m2_addr = m1_addr;
            m1_v = !bus.ram_cen_b; m1_we = !bus.ram_we_b; m1_addr = int'(bus.ram_addr);
            din_q <= (m2_v && !m2_we) ? mem_rd(m2_addr) : 36'h0;
        end
    end

    // Scoreboard: shadow memory in accept order, expected read data queue
    logic [35:0] shadow [int];
    logic [35:0] exp_q [$];

    function automatic logic [35:0] shadow_rd(input int a);
        if (shadow.exists(a)) return shadow[a];
        return init_val(a);
    endfunction

    always @(posedge clock) begin
        if (reset_n && bus.req_valid && bus.req_ready) begin
            if (bus.req_we) shadow[int'(bus.req_addr)] = bus.req_wdata;
            else            exp_q.push_back(shadow_rd(int'(bus.req_addr)));
        end
    end

    always @(negedge clock) begin
        if (reset_n && bus.rsp_valid) begin
            if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
            else                   check("rsp_data", bus.rsp_rdata, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [18:0] a, input logic [35:0] d);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_we_b"},      bus.ram_we_b, 1);
        check({tag, "_cen_b"},     bus.ram_cen_b, 1);
        check({tag, "_doe"},       bus.ram_doe, 0);
        check({tag, "_addr"},      bus.ram_addr, 0);
        check({tag, "_dout"},      bus.ram_dout, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
        check({tag, "_ready_st"},  ready_state, 0);
        check({tag, "_req_ready"}, bus.req_ready, 0);
    endtask

    task automatic bring_up(input string tag);
        locked = 1'b1;
        for (int i = 0; i < 40 && !ready_state; i++) tick();
        check({tag, "_bring_up"}, ready_state, 1);
    endtask

    typedef struct {
        logic        v;
        logic        we;
        logic [18:0] a;
        logic [35:0] d;
        logic        e_web;
        logic [18:0] e_addr;
        logic        e_doe;
        logic [35:0] e_dout;
        logic        e_rv;
        logic [35:0] e_rd;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b1, 19'h00012, 36'h9ABCD1234, 1'b0, 19'h00012, 1'b0, 36'h0,          1'b0, 36'h0};
        tbl[1] = '{1'b0, 1'b0, 19'h00000, 36'h0,         1'b1, 19'h00012, 1'b0, 36'h0,          1'b0, 36'h0};
        tbl[2] = '{1'b0, 1'b0, 19'h00000, 36'h0,         1'b1, 19'h00012, 1'b1, 36'h9ABCD1234, 1'b0, 36'h0};
        tbl[3] = '{1'b1, 1'b0, 19'h00012, 36'h0,         1'b1, 19'h00012, 1'b0, 36'h0,          1'b0, 36'h0};
        tbl[4] = '{1'b1, 1'b1, 19'h00100, 36'h000000001, 1'b0, 19'h00100, 1'b0, 36'h0,          1'b0, 36'h0};
        tbl[5] = '{1'b1, 1'b1, 19'h7FFFF, 36'hFFFFFFFFF, 1'b0, 19'h7FFFF, 1'b0, 36'h0,          1'b0, 36'h0};
        tbl[6] = '{1'b1, 1'b0, 19'h00100, 36'h0,         1'b1, 19'h00100, 1'b1, 36'h000000001, 1'b1, 36'h9ABCD1234};
        tbl[7] = '{1'b0, 1'b0, 19'h00000, 36'h0,         1'b1, 19'h00100, 1'b1, 36'hFFFFFFFFF, 1'b0, 36'h0};
        tbl[8] = '{1'b0, 1'b0, 19'h00000, 36'h0,         1'b1, 19'h00100, 1'b0, 36'h0,          1'b0, 36'h0};
        tbl[9] = '{1'b0, 1'b0, 19'h00000, 36'h0,         1'b1, 19'h00100, 1'b0, 36'h0,          1'b1, 36'h000000001};

        reset_n = 1'b1;
        locked  = 1'b0;
        drive(1'b0, 1'b0, 19'h0, 36'h0);
        #3 reset_n = 1'b0;
        #2 check_reset_vals("por");
        repeat (2) tick();
        #4 reset_n = 1'b1;

        // Lock rises at cycle 10, RUN and req_ready from cycle 26
        for (int i = 0; i < 40 && cyc < 9; i++) tick();
        check("lock_align_cyc", cyc, 9);
        locked = 1'b1;
        for (int n = 10; n <= 27; n++) begin
            tick();
            check($sformatf("settle_c%0d_ready_st", n), ready_state, (n >= 26) ? 1 : 0);
            check($sformatf("settle_c%0d_req_ready", n), bus.req_ready, (n >= 26) ? 1 : 0);
        end

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d);
            tick();
            $display("vec %0d: valid=%0d we=%0d addr=%h wdata=%h -> we_b=%0d addr=%h doe=%0d rsp_valid=%0d",
                     i, tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d,
                     bus.ram_we_b, bus.ram_addr, bus.ram_doe, bus.rsp_valid);
            check($sformatf("tbl%0d_we_b", i),  bus.ram_we_b, tbl[i].e_web);
            check($sformatf("tbl%0d_addr", i),  bus.ram_addr, tbl[i].e_addr);
            check($sformatf("tbl%0d_cen_b", i), bus.ram_cen_b, 0);
            check($sformatf("tbl%0d_doe", i),   bus.ram_doe, tbl[i].e_doe);
            if (tbl[i].e_doe) check($sformatf("tbl%0d_dout", i), bus.ram_dout, tbl[i].e_dout);
            check($sformatf("tbl%0d_rsp_valid", i), bus.rsp_valid, tbl[i].e_rv);
            if (tbl[i].e_rv) check($sformatf("tbl%0d_rsp_rdata", i), bus.rsp_rdata, tbl[i].e_rd);
        end

        // Back-to-back R(A) W(B) R(C)
        for (int k = 0; k <= 6; k++) begin
            case (k)
                0:       drive(1'b1, 1'b0, 19'h00012, 36'h0);
                1:       drive(1'b1, 1'b1, 19'h00020, 36'h123456789);
                2:       drive(1'b1, 1'b0, 19'h7FFFF, 36'h0);
                default: drive(1'b0, 1'b0, 19'h0, 36'h0);
            endcase
            tick();
            $display("b2b E%0d: rsp_valid=%0d rsp_rdata=%h doe=%0d", k, bus.rsp_valid, bus.rsp_rdata, bus.ram_doe);
            check($sformatf("b2b_E%0d_rsp_valid", k), bus.rsp_valid, (k == 3 || k == 5) ? 1 : 0);
            check($sformatf("b2b_E%0d_doe", k), bus.ram_doe, (k == 3) ? 1 : 0);
            if (k == 3) begin
                check("b2b_E3_rdata", bus.rsp_rdata, 36'h9ABCD1234);
                check("b2b_E3_dout",  bus.ram_dout, 36'h123456789);
            end
            if (k == 5) check("b2b_E5_rdata", bus.rsp_rdata, 36'hFFFFFFFFF);
        end

        // Lock lost one cycle after a read is accepted
        drive(1'b1, 1'b0, 19'h00100, 36'h0);
        tick();
        locked = 1'b0;
        drive(1'b0, 1'b0, 19'h0, 36'h0);
        #1 check("lockloss_req_ready_now", bus.req_ready, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            $display("lockloss E%0d: ready_state=%0d rsp_valid=%0d doe=%0d", k, ready_state, bus.rsp_valid, bus.ram_doe);
            check($sformatf("lockloss_E%0d_ready_st", k), ready_state, 0);
            check($sformatf("lockloss_E%0d_rsp_valid", k), bus.rsp_valid, 0);
            check($sformatf("lockloss_E%0d_doe", k), bus.ram_doe, 0);
            check($sformatf("lockloss_E%0d_we_b", k), bus.ram_we_b, 1);
        end
        exp_q.delete();

        // Reset pulsed low in the middle of a burst
        bring_up("pre_rst");
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, k[0], 19'h40000 + 19'(k), 36'h0_5555_0000 + 36'(k));
            tick();
        end
        #5 reset_n = 1'b0;
        #1 check_reset_vals("midburst");
        exp_q.delete();
        drive(1'b0, 1'b0, 19'h0, 36'h0);
        tick();
        check_reset_vals("midburst_held");
        #4 reset_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            check($sformatf("restart_E%0d_ready_st", k), ready_state, (k >= 17) ? 1 : 0);
            check($sformatf("restart_E%0d_rsp_valid", k), bus.rsp_valid, 0);
            check($sformatf("restart_E%0d_doe", k), bus.ram_doe, 0);
        end

        // Random stream; the scoreboard checks every returned read
        for (int i = 0; i < 10000; i++) begin
            logic [35:0] d;
            d = {4'($urandom), $urandom};
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 19'($urandom_range(0, 31)), d);
            tick();
        end
        drive(1'b0, 1'b0, 19'h0, 36'h0);
        repeat (6) tick();
        check("random_drain_pending", exp_q.size(), 0);
        check("random_ready_st", ready_state, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
